uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL provide the following parameter: DATA_WIDTH, 8, number of data bits per frame (5-8 legal).
REQ-002 The block SHALL provide the following parameter: SB_TICK, 16, stop-bit length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 The block SHALL provide the following parameter: PARITY_EN, 0, 1 inserts a parity bit after the data bits.
REQ-004 The block SHALL provide the following parameter: PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
REQ-005 The block SHALL have the port: clk  input  1  single clock; all state on rising edge.
REQ-006 The block SHALL have the port: reset  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have the port: s_tick  input  1  16x-baud oversample strobe, one clk wide.
REQ-008 The block SHALL have the port: fifo_empty  input  1  empty flag of upstream FWFT FIFO.
REQ-009 The block SHALL have the port: fifo_data  input  DATA_WIDTH  FWFT FIFO head word, valid whenever fifo_empty = 0.
REQ-010 The block SHALL have the port: fifo_rd  output  1  one-cycle pop strobe to FIFO rd.
REQ-011 The block SHALL have the port: tx  output  1  serial line, idle high, registered.
REQ-012 The block SHALL have the port: tx_busy  output  1  high in any state other than IDLE.
REQ-013 The block SHALL have the port: tx_done_tick  output  1  one-cycle pulse at end of stop bit.

Function
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP; PARITY SHALL be unreachable when PARITY_EN = 0.
REQ-015 In IDLE with fifo_empty = 0, the block SHALL, in the same cycle: drive fifo_rd = 1 (combinational), load fifo_data into the shift register, compute the parity bit from fifo_data, clear the tick counter s, and go to START.
REQ-016 fifo_rd SHALL never be asserted while fifo_empty = 1, and SHALL be asserted at most once per frame.
REQ-017 tx SHALL fall to 0 on the clk edge that enters START, one cycle after fifo_rd is asserted.
REQ-018 The counter s (4 bits, or wide enough for SB_TICK-1) SHALL increment only on cycles where s_tick = 1; without s_tick, all state SHALL hold.
REQ-019 START: tx = 0; on s_tick with s = 15, set s = 0, n = 0 and go to DATA.
REQ-020 DATA: tx = shift register bit 0 (LSB first); on s_tick with s = 15, shift right, set s = 0 and increment n.
REQ-021 DATA exit: when n = DATA_WIDTH-1, the next state SHALL be PARITY if PARITY_EN = 1, otherwise STOP.
REQ-022 PARITY: tx = XOR of the data bits, XOR PARITY_ODD; on s_tick with s = 15, set s = 0 and go to STOP.
REQ-023 STOP: tx = 1; on s_tick with s = SB_TICK-1, go to IDLE and pulse tx_done_tick for exactly one cycle.
REQ-024 Back-to-back: if fifo_empty = 0 on the first IDLE cycle after tx_done_tick, the next frame SHALL start with no idle gap beyond that single cycle; tx SHALL stay 1 during it.
REQ-025 Frame length SHALL be exactly 16*(1+DATA_WIDTH+PARITY_EN)+SB_TICK s_tick pulses.
REQ-026 A change of fifo_data or fifo_empty after the load SHALL NOT affect the frame in progress.
REQ-027 tx_busy SHALL be 0 only in IDLE.

Reset
REQ-028 While reset = 0, regardless of clk: state = IDLE, tx = 1, s = 0, n = 0, shift register = 0, tx_busy = 0, tx_done_tick = 0, fifo_rd = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, forcing tx = 1; the aborted word is not re-sent.
REQ-030 After reset release, the block SHALL start the next frame on the first cycle where fifo_empty = 0.

Verification
REQ-031 The bench SHALL cover: DATA_WIDTH 8, no parity, SB_TICK 16, fifo_data 0x55 -> one fifo_rd pulse; tx sequence 0,1,0,1,0,1,0,1,0,1, each 16 ticks; 160 ticks total; one tx_done_tick.
REQ-032 The bench SHALL cover: PARITY_EN 1, even parity, data 0x07 -> parity bit 1; PARITY_ODD 1 -> parity bit 0; 176 ticks per frame.
REQ-033 The bench SHALL cover: FIFO preloaded with 0xA3, 0x3C, 0xFF -> three fifo_rd pulses, each one cycle after the prior tx_done_tick; exactly one idle-high cycle between frames; bytes are received in order.
REQ-034 The bench SHALL cover: fifo_empty held 1 for 1000 cycles -> fifo_rd = 0, tx = 1 and tx_busy = 0 throughout.
REQ-035 The bench SHALL cover: reset driven low at tick 40 of a 0x81 frame -> tx = 1 and tx_busy = 0 asynchronously; after release with an empty FIFO, no further activity.
REQ-036 The bench SHALL cover: s_tick gapped irregularly (1-50 clk spacing) -> bit widths measured in ticks remain exactly 16, and all outputs hold between ticks.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter fed by a first-word-fall-through FIFO.
// Sends start bit, DATA_WIDTH data bits LSB first, optional parity, then stop.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int SB_TICK    = 16,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_tick,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(15);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_reg, state_next;
  logic [S_W-1:0]        s_reg, s_next;
  logic [N_W-1:0]        n_reg, n_next;
  logic [DATA_WIDTH-1:0] b_reg, b_next;
  logic                  p_reg, p_next;
  logic                  tx_reg, tx_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      p_reg     <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      p_reg     <= p_next;
      tx_reg    <= tx_next;
    end
  end

  // Word and parity are captured at the pop, so later FIFO changes cannot disturb the frame.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    p_next     = p_reg;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = START;
          s_next     = '0;
          b_next     = fifo_data;
          p_next     = (^fifo_data) ^ PARITY_ODD;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            state_next = DATA;
            s_next     = '0;
            n_next     = '0;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == N_LAST) begin
              state_next = PARITY_EN ? PARITY : STOP;
            end else begin
              n_next = n_reg + 1'b1;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_reg == S_BIT_LAST) begin
            state_next = STOP;
            s_next     = '0;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == S_STOP_LAST) begin
            state_next = IDLE;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx is registered, so its next value is decoded from the state being entered.
  always_comb begin
    fifo_rd      = reset && (state_reg == IDLE) && !fifo_empty;
    tx_done_tick = (state_reg == STOP) && s_tick && (s_reg == S_STOP_LAST);
    tx_busy      = (state_reg != IDLE);
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      PARITY:  tx_next = p_next;
      default: tx_next = 1'b1;
    endcase
  end

  assign tx = tx_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three instances (no parity, even, odd) share
// clock, reset and tick; one FIFO model feeds whichever instance is selected.
module tb_uart_tx;

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       par_bit;
    int         ticks;
  } vec_t;

  typedef struct {
    logic [255:0] bits;
    int           ticks;
  } rx_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       q_empty = 1'b1;
  int         sel = 0;

  logic fifo_empty_np, fifo_empty_pe, fifo_empty_po;
  logic rd_np, rd_pe, rd_po;
  logic tx_np, tx_pe, tx_po;
  logic busy_np, busy_pe, busy_po;
  logic done_np, done_pe, done_po;
  logic m_rd, m_tx, m_busy, m_done;

  int n_compared = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  assign fifo_empty_np = (sel != 0) || q_empty;
  assign fifo_empty_pe = (sel != 1) || q_empty;
  assign fifo_empty_po = (sel != 2) || q_empty;

  uart_tx #(.DATA_WIDTH(8), .SB_TICK(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_np (
    .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fifo_empty_np),
    .fifo_data(fifo_data), .fifo_rd(rd_np), .tx(tx_np), .tx_busy(busy_np),
    .tx_done_tick(done_np)
  );

  uart_tx #(.DATA_WIDTH(8), .SB_TICK(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_pe (
    .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fifo_empty_pe),
    .fifo_data(fifo_data), .fifo_rd(rd_pe), .tx(tx_pe), .tx_busy(busy_pe),
    .tx_done_tick(done_pe)
  );

  uart_tx #(.DATA_WIDTH(8), .SB_TICK(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_po (
    .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fifo_empty_po),
    .fifo_data(fifo_data), .fifo_rd(rd_po), .tx(tx_po), .tx_busy(busy_po),
    .tx_done_tick(done_po)
  );

  always_comb begin
    case (sel)
      1: begin m_rd = rd_pe; m_tx = tx_pe; m_busy = busy_pe; m_done = done_pe; end
      2: begin m_rd = rd_po; m_tx = tx_po; m_busy = busy_po; m_done = done_po; end
      default: begin m_rd = rd_np; m_tx = tx_np; m_busy = busy_np; m_done = done_np; end
    endcase
  end

  // FWFT FIFO model: pops on the edge where the selected instance strobes fifo_rd.
  logic [7:0] fifo_q[$];

  task automatic fifo_refresh();
    q_empty   = (fifo_q.size() == 0);
    fifo_data = q_empty ? 8'h00 : fifo_q[0];
  endtask

  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
    fifo_refresh();
  endtask

  always @(posedge clk) begin
    logic pop_now;
    pop_now = m_rd;
    #1;
    if (pop_now && fifo_q.size() > 0) fifo_q.delete(0);
    fifo_refresh();
  end

  bit tick_on = 1'b0;
  bit tick_random = 1'b0;
  int tick_gap = 3;

  initial begin
    int wait_left;
    wait_left = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!tick_on) begin
        s_tick = 1'b0;
      end else if (wait_left == 0) begin
        s_tick    = 1'b1;
        wait_left = (tick_random ? int'($urandom_range(50, 1)) : tick_gap) - 1;
      end else begin
        s_tick = 1'b0;
        wait_left--;
      end
    end
  end

  // Line monitor: logs tx once per tick while busy and records strobe timing.
  int           cycle = 0;
  logic [255:0] cur_bits = '0;
  int           cur_ticks = 0;
  rx_t          rx_q[$];
  int           rd_cycles[$];
  int           done_cycles[$];
  logic         rd_tx[$];
  logic         after_rd_tx[$];
  bit           prev_rd = 1'b0;
  bit           prev_tick = 1'b0;
  logic         prev_tx = 1'b1;
  logic         prev_busy = 1'b0;
  int           hold_errs = 0;
  int           stray_rd = 0;

  always @(negedge clk) begin
    rx_t fr;
    cycle++;
    if (!reset) begin
      cur_bits  = '0;
      cur_ticks = 0;
    end else begin
      if (m_rd) begin
        rd_cycles.push_back(cycle);
        rd_tx.push_back(m_tx);
      end
      if (prev_rd) after_rd_tx.push_back(m_tx);
      if (s_tick && m_busy) begin
        if (cur_ticks < 256) cur_bits[cur_ticks] = m_tx;
        cur_ticks++;
      end
      if (m_done) begin
        fr.bits  = cur_bits;
        fr.ticks = cur_ticks;
        rx_q.push_back(fr);
        done_cycles.push_back(cycle);
        cur_bits  = '0;
        cur_ticks = 0;
      end
      if (!prev_tick && !prev_rd && (m_tx !== prev_tx || m_busy !== prev_busy)) hold_errs++;
    end
    if ((rd_np && fifo_empty_np) || (rd_pe && fifo_empty_pe) || (rd_po && fifo_empty_po))
      stray_rd++;
    prev_rd   = m_rd;
    prev_tick = s_tick;
    prev_tx   = m_tx;
    prev_busy = m_busy;
  end

  task automatic check_output(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Expected per-tick line image: 16 ticks per bit window, one stop window.
  function automatic logic [255:0] frame_bits(input logic [7:0] data, input bit has_par,
                                              input logic par_bit);
    logic [255:0] f;
    int nwin;
    f    = '0;
    nwin = has_par ? 11 : 10;
    for (int k = 0; k < 16 * nwin; k++) begin
      int w;
      w = k / 16;
      if (w == 0)                 f[k] = 1'b0;
      else if (w <= 8)            f[k] = data[w-1];
      else if (w == 9 && has_par) f[k] = par_bit;
      else                        f[k] = 1'b1;
    end
    return f;
  endfunction

  task automatic clear_logs();
    rx_q.delete();
    rd_cycles.delete();
    done_cycles.delete();
    rd_tx.delete();
    after_rd_tx.delete();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_output("frames_received", rx_q.size(), n);
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(posedge clk);
    #1;
    sel = v.sel;
    clear_logs();
    push_word(v.data);
  endtask

  task automatic check_frame(input string name, input int idx, input logic [7:0] data,
                             input bit has_par, input logic par_bit, input int ticks);
    if (rx_q.size() > idx) begin
      check_output({name, " bits"}, rx_q[idx].bits, frame_bits(data, has_par, par_bit));
      check_output({name, " ticks"}, rx_q[idx].ticks, ticks);
    end
  endtask

  initial begin
    vec_t vecs[9];
    vec_t v;
    int   viol;
    int   k;

    vecs[0] = '{0, 8'h55, 1'b0, 160};
    vecs[1] = '{1, 8'h07, 1'b1, 176};
    vecs[2] = '{2, 8'h07, 1'b0, 176};
    vecs[3] = '{0, 8'h00, 1'b0, 160};
    vecs[4] = '{0, 8'hFF, 1'b0, 160};
    vecs[5] = '{1, 8'hA5, 1'b0, 176};
    vecs[6] = '{2, 8'h80, 1'b0, 176};
    vecs[7] = '{1, 8'h80, 1'b1, 176};
    vecs[8] = '{2, 8'h00, 1'b1, 176};

    reset = 1'b0;
    fifo_refresh();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset tx", {tx_np, tx_pe, tx_po}, 3'b111);
    check_output("reset busy", {busy_np, busy_pe, busy_po}, 3'b000);
    check_output("reset done", {done_np, done_pe, done_po}, 3'b000);
    check_output("reset rd", {rd_np, rd_pe, rd_po}, 3'b000);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    tick_on = 1'b1;

    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i]);
      wait_frames(1, 3000);
      repeat (5) @(negedge clk);
      check_frame($sformatf("vec%0d", i), 0, vecs[i].data, vecs[i].sel != 0,
                  vecs[i].par_bit, vecs[i].ticks);
      check_output($sformatf("vec%0d rd pulses", i), rd_cycles.size(), 1);
      check_output($sformatf("vec%0d done pulses", i), done_cycles.size(), 1);
    end

    $display("[TB] back-to-back frames");
    @(posedge clk);
    #1;
    sel = 0;
    clear_logs();
    push_word(8'hA3);
    push_word(8'h3C);
    push_word(8'hFF);
    wait_frames(3, 6000);
    repeat (5) @(negedge clk);
    check_frame("b2b0", 0, 8'hA3, 1'b0, 1'b0, 160);
    check_frame("b2b1", 1, 8'h3C, 1'b0, 1'b0, 160);
    check_frame("b2b2", 2, 8'hFF, 1'b0, 1'b0, 160);
    check_output("b2b rd pulses", rd_cycles.size(), 3);
    check_output("b2b done pulses", done_cycles.size(), 3);
    for (int i = 1; i < 3; i++) begin
      if (rd_cycles.size() > i && done_cycles.size() >= i)
        check_output($sformatf("b2b gap%0d", i), rd_cycles[i] - done_cycles[i-1], 1);
    end
    viol = 0;
    foreach (rd_tx[i]) if (rd_tx[i] !== 1'b1) viol++;
    foreach (after_rd_tx[i]) if (after_rd_tx[i] !== 1'b0) viol++;
    check_output("b2b idle/start levels", viol, 0);
    check_output("b2b start count", after_rd_tx.size(), 3);

    $display("[TB] empty FIFO for 1000 cycles");
    clear_logs();
    viol = 0;
    repeat (1000) begin
      @(negedge clk);
      if (m_rd || m_tx !== 1'b1 || m_busy !== 1'b0) viol++;
    end
    check_output("idle quiet", viol, 0);

    $display("[TB] irregular tick spacing");
    @(posedge clk);
    #1;
    tick_random = 1'b1;
    v = '{1, 8'h5A, 1'b0, 176};
    apply_stimulus(v);
    wait_frames(1, 12000);
    check_frame("gapped", 0, 8'h5A, 1'b1, 1'b0, 176);
    check_output("gapped hold", hold_errs, 0);
    @(posedge clk);
    #1;
    tick_random = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] reset mid-frame");
    v = '{0, 8'h81, 1'b0, 160};
    apply_stimulus(v);
    k = 0;
    while (cur_ticks < 40 && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_output("abort point", cur_ticks, 40);
    check_output("tx before abort", m_tx, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    check_output("abort tx", tx_np, 1'b1);
    check_output("abort busy", busy_np, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    clear_logs();
    reset = 1'b1;
    viol = 0;
    repeat (300) begin
      @(negedge clk);
      if (m_rd || m_tx !== 1'b1 || m_busy !== 1'b0) viol++;
    end
    check_output("post-abort quiet", viol, 0);
    check_output("post-abort rd", rd_cycles.size(), 0);
    check_output("post-abort done", done_cycles.size(), 0);

    $display("[TB] word waiting across reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_word(8'h3C);
    @(negedge clk);
    check_output("rd held in reset", m_rd, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_logs();
    @(negedge clk);
    check_output("rd after release", m_rd, 1'b1);
    wait_frames(1, 3000);
    check_frame("release", 0, 8'h3C, 1'b0, 1'b0, 160);

    check_output("rd while empty", stray_rd, 0);
    check_output("hold between ticks", hold_errs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
